decode_stage: RTL and testbench



---
 rtl/decode_stage.sv | 169 ++++++++++++++++
 tb/tb_decode_stage.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// MIPS ID stage: register file, main decode, branch/jump resolution in ID,
// load-use and branch-operand hazard detection, and the ID/EX pipeline register.
module decode_stage #(
    parameter int unsigned NB_BITS = 32,
    parameter int unsigned NB_REG  = 5
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NB_BITS-1:0] i_if_id_pc,
    input  logic [NB_BITS-1:0] i_if_id_instr,
    input  logic               i_wb_we,
    input  logic [NB_REG-1:0]  i_wb_addr,
    input  logic [NB_BITS-1:0] i_wb_data,
    input  logic               i_ex_mem_reg_we,
    input  logic [NB_REG-1:0]  i_ex_mem_wa,
    output logic               o_pc_we,
    output logic               o_if_id_we,
    output logic               o_ctr_flush,
    output logic               o_ctr_beq,
    output logic               o_ctr_jmp,
    output logic [NB_BITS-1:0] o_brq_addr,
    output logic [NB_BITS-1:0] o_jmp_addr,
    output logic [NB_BITS-1:0] o_id_ex_pc,
    output logic [NB_BITS-1:0] o_id_ex_rs_data,
    output logic [NB_BITS-1:0] o_id_ex_rt_data,
    output logic [NB_BITS-1:0] o_id_ex_imm,
    output logic [NB_REG-1:0]  o_id_ex_rs,
    output logic [NB_REG-1:0]  o_id_ex_rt,
    output logic [NB_REG-1:0]  o_id_ex_wa,
    output logic [5:0]         o_id_ex_funct,
    output logic [5:0]         o_id_ex_ctrl
);

    localparam int unsigned NREGS = 2 ** NB_REG;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    // ctrl bit positions: {reg_we, mem_rd, mem_wr, mem_to_reg, alu_src, is_rtype}
    localparam int unsigned C_REG_WE = 5;
    localparam int unsigned C_MEM_RD = 4;

    logic [NB_BITS-1:0] r_regs [NREGS];

    logic [5:0]         w_op;
    logic [NB_REG-1:0]  w_rs;
    logic [NB_REG-1:0]  w_rt;
    logic [NB_REG-1:0]  w_rd;
    logic [NB_BITS-1:0] w_rs_data;
    logic [NB_BITS-1:0] w_rt_data;
    logic [NB_BITS-1:0] w_imm;
    logic [5:0]         w_ctrl;
    logic [NB_REG-1:0]  w_wa;
    logic               w_uses_rt;
    logic               w_is_br;
    logic               w_is_j;
    logic               w_br_taken;
    logic               w_stall_lu;
    logic               w_stall_br;
    logic               w_stall;

    assign w_op  = i_if_id_instr[31:26];
    assign w_rs  = i_if_id_instr[25:21];
    assign w_rt  = i_if_id_instr[20:16];
    assign w_rd  = i_if_id_instr[15:11];
    assign w_imm = {{(NB_BITS-16){i_if_id_instr[15]}}, i_if_id_instr[15:0]};

    // Write-through lets a same-cycle WB feed the reader, which also resolves branch stalls.
    always_comb begin
        w_rs_data = r_regs[w_rs];
        w_rt_data = r_regs[w_rt];
        if (i_wb_we && (i_wb_addr != '0) && (i_wb_addr == w_rs)) w_rs_data = i_wb_data;
        if (i_wb_we && (i_wb_addr != '0) && (i_wb_addr == w_rt)) w_rt_data = i_wb_data;
        if (w_rs == '0) w_rs_data = '0;
        if (w_rt == '0) w_rt_data = '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < int'(NREGS); i++) r_regs[i] <= '0;
        end else if (i_wb_we && (i_wb_addr != '0)) begin
            r_regs[i_wb_addr] <= i_wb_data;
        end
    end

    always_comb begin
        w_ctrl    = 6'b000000;
        w_wa      = '0;
        w_uses_rt = 1'b0;
        w_is_br   = 1'b0;
        w_is_j    = 1'b0;
        case (w_op)
            OP_R: begin
                w_ctrl    = 6'b100001;
                w_wa      = w_rd;
                w_uses_rt = 1'b1;
            end
            OP_ADDI: begin
                w_ctrl = 6'b100010;
                w_wa   = w_rt;
            end
            OP_LW: begin
                w_ctrl = 6'b110110;
                w_wa   = w_rt;
            end
            OP_SW: begin
                w_ctrl    = 6'b001010;
                w_uses_rt = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                w_uses_rt = 1'b1;
                w_is_br   = 1'b1;
            end
            OP_J:    w_is_j = 1'b1;
            default: ;
        endcase
    end

    assign w_br_taken = (w_op == OP_BEQ) ? (w_rs_data == w_rt_data) : (w_rs_data != w_rt_data);

    assign w_stall_lu = o_id_ex_ctrl[C_MEM_RD] && (o_id_ex_wa != '0) &&
                        ((o_id_ex_wa == w_rs) || (w_uses_rt && (o_id_ex_wa == w_rt)));

    assign w_stall_br = w_is_br &&
        (((w_rs != '0) && ((o_id_ex_ctrl[C_REG_WE] && (o_id_ex_wa == w_rs)) ||
                           (i_ex_mem_reg_we && (i_ex_mem_wa == w_rs)))) ||
         ((w_rt != '0) && ((o_id_ex_ctrl[C_REG_WE] && (o_id_ex_wa == w_rt)) ||
                           (i_ex_mem_reg_we && (i_ex_mem_wa == w_rt)))));

    assign w_stall = w_stall_lu | w_stall_br;

    assign o_pc_we     = i_rst | ~w_stall;
    assign o_if_id_we  = i_rst | ~w_stall;
    assign o_ctr_beq   = ~i_rst & ~w_stall & w_is_br & w_br_taken;
    assign o_ctr_jmp   = ~i_rst & ~w_stall & w_is_j;
    assign o_ctr_flush = o_ctr_beq | o_ctr_jmp;
    assign o_brq_addr  = i_if_id_pc + (w_imm << 2);
    assign o_jmp_addr  = {i_if_id_pc[NB_BITS-1:NB_BITS-4], i_if_id_instr[25:0], 2'b00};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_id_ex_pc      <= '0;
            o_id_ex_rs_data <= '0;
            o_id_ex_rt_data <= '0;
            o_id_ex_imm     <= '0;
            o_id_ex_rs      <= '0;
            o_id_ex_rt      <= '0;
            o_id_ex_wa      <= '0;
            o_id_ex_funct   <= '0;
            o_id_ex_ctrl    <= '0;
        end else begin
            o_id_ex_pc      <= i_if_id_pc;
            o_id_ex_rs_data <= w_rs_data;
            o_id_ex_rt_data <= w_rt_data;
            o_id_ex_imm     <= w_imm;
            o_id_ex_rs      <= w_rs;
            o_id_ex_rt      <= w_rt;
            o_id_ex_funct   <= i_if_id_instr[5:0];
            o_id_ex_wa      <= w_stall ? '0 : w_wa;
            o_id_ex_ctrl    <= w_stall ? 6'b000000 : w_ctrl;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, write-through, load-use and branch
// stalls, branch/jump redirect and reset during a stall.
module tb_decode_stage;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [31:0] i_if_id_pc;
    logic [31:0] i_if_id_instr;
    logic        i_wb_we;
    logic [4:0]  i_wb_addr;
    logic [31:0] i_wb_data;
    logic        i_ex_mem_reg_we;
    logic [4:0]  i_ex_mem_wa;
    logic        o_pc_we, o_if_id_we, o_ctr_flush, o_ctr_beq, o_ctr_jmp;
    logic [31:0] o_brq_addr, o_jmp_addr;
    logic [31:0] o_id_ex_pc, o_id_ex_rs_data, o_id_ex_rt_data, o_id_ex_imm;
    logic [4:0]  o_id_ex_rs, o_id_ex_rt, o_id_ex_wa;
    logic [5:0]  o_id_ex_funct, o_id_ex_ctrl;

    int n_tests = 0;
    int n_fail  = 0;

    decode_stage #(.NB_BITS(32), .NB_REG(5)) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_if_id_pc      (i_if_id_pc),
        .i_if_id_instr   (i_if_id_instr),
        .i_wb_we         (i_wb_we),
        .i_wb_addr       (i_wb_addr),
        .i_wb_data       (i_wb_data),
        .i_ex_mem_reg_we (i_ex_mem_reg_we),
        .i_ex_mem_wa     (i_ex_mem_wa),
        .o_pc_we         (o_pc_we),
        .o_if_id_we      (o_if_id_we),
        .o_ctr_flush     (o_ctr_flush),
        .o_ctr_beq       (o_ctr_beq),
        .o_ctr_jmp       (o_ctr_jmp),
        .o_brq_addr      (o_brq_addr),
        .o_jmp_addr      (o_jmp_addr),
        .o_id_ex_pc      (o_id_ex_pc),
        .o_id_ex_rs_data (o_id_ex_rs_data),
        .o_id_ex_rt_data (o_id_ex_rt_data),
        .o_id_ex_imm     (o_id_ex_imm),
        .o_id_ex_rs      (o_id_ex_rs),
        .o_id_ex_rt      (o_id_ex_rt),
        .o_id_ex_wa      (o_id_ex_wa),
        .o_id_ex_funct   (o_id_ex_funct),
        .o_id_ex_ctrl    (o_id_ex_ctrl)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs then change 1ns after the edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    initial begin
        i_rst = 1'b1;
        i_if_id_pc = 32'h0;
        i_if_id_instr = 32'h0;
        i_wb_we = 1'b0;
        i_wb_addr = 5'd0;
        i_wb_data = 32'h0;
        i_ex_mem_reg_we = 1'b0;
        i_ex_mem_wa = 5'd0;
        tick();
        tick();
        check_eq("rst_ctrl", {26'h0, o_id_ex_ctrl}, 32'h0);
        check_eq("rst_pc", o_id_ex_pc, 32'h0);
        check_eq("rst_pc_we", {31'h0, o_pc_we}, 32'h1);
        check_eq("rst_if_id_we", {31'h0, o_if_id_we}, 32'h1);
        check_eq("rst_flush", {31'h0, o_ctr_flush}, 32'h0);

        // 1. write-through: WB $5 while add $3,$5,$0 reads it
        i_rst = 1'b0;
        i_wb_we = 1'b1; i_wb_addr = 5'd5; i_wb_data = 32'h1234;
        i_if_id_pc = 32'h10; i_if_id_instr = 32'h00A01820;
        tick();
        check_eq("t1_rs_data", o_id_ex_rs_data, 32'h1234);
        check_eq("t1_ctrl", {26'h0, o_id_ex_ctrl}, 32'h21);
        check_eq("t1_wa", {27'h0, o_id_ex_wa}, 32'd3);
        check_eq("t1_funct", {26'h0, o_id_ex_funct}, 32'h20);
        check_eq("t1_pc", o_id_ex_pc, 32'h10);

        // 2. load-use: lw $2,0($0) then add $4,$2,$1
        i_wb_we = 1'b0;
        i_if_id_instr = 32'h8C020000;
        tick();
        check_eq("t2_lw_ctrl", {26'h0, o_id_ex_ctrl}, 32'h36);
        i_if_id_instr = 32'h00412020;
        settle();
        check_eq("t2_stall_pc_we", {31'h0, o_pc_we}, 32'h0);
        check_eq("t2_stall_if_id_we", {31'h0, o_if_id_we}, 32'h0);
        tick();
        check_eq("t2_bubble", {26'h0, o_id_ex_ctrl}, 32'h0);
        check_eq("t2_resume_pc_we", {31'h0, o_pc_we}, 32'h1);
        tick();
        check_eq("t2_add_ctrl", {26'h0, o_id_ex_ctrl}, 32'h21);
        check_eq("t2_add_wa", {27'h0, o_id_ex_wa}, 32'd4);

        // 3. beq $1,$1,+3 taken; beq $5,$0,-1 not taken
        i_if_id_pc = 32'h100; i_if_id_instr = 32'h10210003;
        settle();
        check_eq("t3_beq", {31'h0, o_ctr_beq}, 32'h1);
        check_eq("t3_flush", {31'h0, o_ctr_flush}, 32'h1);
        check_eq("t3_brq", o_brq_addr, 32'h10C);
        check_eq("t3_jmp", {31'h0, o_ctr_jmp}, 32'h0);
        i_if_id_instr = 32'h10A0FFFF;
        settle();
        check_eq("t3_nt_beq", {31'h0, o_ctr_beq}, 32'h0);
        check_eq("t3_nt_flush", {31'h0, o_ctr_flush}, 32'h0);
        check_eq("t3_neg_brq", o_brq_addr, 32'hFC);
        tick();
        check_eq("t3_br_ctrl", {26'h0, o_id_ex_ctrl}, 32'h0);

        // 4. j 0x40 with pc+4 = 0x00400004
        i_if_id_pc = 32'h00400004; i_if_id_instr = 32'h08000040;
        settle();
        check_eq("t4_jmp", {31'h0, o_ctr_jmp}, 32'h1);
        check_eq("t4_flush", {31'h0, o_ctr_flush}, 32'h1);
        check_eq("t4_beq", {31'h0, o_ctr_beq}, 32'h0);
        check_eq("t4_addr", o_jmp_addr, 32'h00000100);

        // 5. addi $7,$0,5 then bne $7,$0,+2: two stall cycles, resolve via WB
        i_if_id_pc = 32'h200; i_if_id_instr = 32'h20070005;
        tick();
        check_eq("t5_addi_ctrl", {26'h0, o_id_ex_ctrl}, 32'h22);
        check_eq("t5_addi_imm", o_id_ex_imm, 32'h5);
        i_if_id_pc = 32'h204; i_if_id_instr = 32'h14E00002;
        settle();
        check_eq("t5_ex_stall", {31'h0, o_pc_we}, 32'h0);
        check_eq("t5_ex_nobr", {31'h0, o_ctr_beq}, 32'h0);
        tick();
        i_ex_mem_reg_we = 1'b1; i_ex_mem_wa = 5'd7;
        settle();
        check_eq("t5_mem_stall", {31'h0, o_if_id_we}, 32'h0);
        tick();
        i_ex_mem_reg_we = 1'b0;
        i_wb_we = 1'b1; i_wb_addr = 5'd7; i_wb_data = 32'h5;
        settle();
        check_eq("t5_wb_pc_we", {31'h0, o_pc_we}, 32'h1);
        check_eq("t5_wb_bne", {31'h0, o_ctr_beq}, 32'h1);
        check_eq("t5_wb_brq", o_brq_addr, 32'h20C);
        tick();
        i_wb_we = 1'b0;

        // 6. reset during a load-use stall; $0 writes ignored
        i_if_id_instr = 32'h8C020000;
        tick();
        i_if_id_instr = 32'h00412020;
        settle();
        check_eq("t6_pre_stall", {31'h0, o_pc_we}, 32'h0);
        i_rst = 1'b1;
        i_wb_we = 1'b1; i_wb_addr = 5'd6; i_wb_data = 32'hBEEF;
        settle();
        check_eq("t6_rst_pc_we", {31'h0, o_pc_we}, 32'h1);
        tick();
        check_eq("t6_ctrl", {26'h0, o_id_ex_ctrl}, 32'h0);
        check_eq("t6_wa", {27'h0, o_id_ex_wa}, 32'h0);
        check_eq("t6_rs_data", o_id_ex_rs_data, 32'h0);
        check_eq("t6_pc_we", {31'h0, o_pc_we}, 32'h1);
        // $6 write was under reset, $5 cleared by reset, $0 write ignored
        i_rst = 1'b0;
        i_wb_we = 1'b1; i_wb_addr = 5'd0; i_wb_data = 32'hDEAD;
        i_if_id_instr = 32'h00C51820;
        tick();
        check_eq("t6_r6", o_id_ex_rs_data, 32'h0);
        check_eq("t6_r5", o_id_ex_rt_data, 32'h0);
        i_wb_we = 1'b0;
        i_if_id_instr = 32'h00000020;
        tick();
        check_eq("t6_r0", o_id_ex_rs_data, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
